// File: rtl/dw_conv5x5x16.sv
// dw_conv5x5x16: depthwise 5x5 conv, 16 channels, fixed 4-stage pipeline.
// Define DW5_RELU6_EN to clamp results to [0, 6.0] in the last stage.
module dw_conv5x5x16 #(
  parameter int bitsize   = 14,
  parameter int FRAC_BITS = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [25*16*bitsize-1:0] window_in,
  input  logic                     window_valid,
  input  logic                     window_last,
  input  logic                     wt_wr_en,
  input  logic [3:0]               wt_ch,
  input  logic [26*bitsize-1:0]    wt_data,
  output logic [16*bitsize-1:0]    out_pixels,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [11:0]              window_cnt
);

  localparam int PW = 2*bitsize;

  typedef logic signed [bitsize-1:0] pix_t;
  typedef logic signed [PW-1:0]      prod_t;
  typedef logic signed [PW+2:0]      part_t;
  typedef logic signed [PW+5:0]      sum_t;
  typedef logic signed [PW+6:0]      rnd_t;

  localparam rnd_t MAXV = rnd_t'((1 << (bitsize-1)) - 1);
  localparam rnd_t MINV = rnd_t'(-(1 << (bitsize-1)));
  localparam rnd_t HALF = rnd_t'(1 << (FRAC_BITS-1));
`ifdef DW5_RELU6_EN
  localparam rnd_t R6   = rnd_t'(6 << FRAC_BITS);
`endif

  logic [26*bitsize-1:0] r_coef  [16];
  prod_t                 r_prod  [16][25];
  pix_t                  r_bias1 [16];
  pix_t                  r_bias2 [16];
  part_t                 r_part  [16][5];
  sum_t                  r_sum   [16];
  logic [3:0]            r_vld;
  logic [3:0]            r_lst;
  logic [11:0]           r_cnt;
  logic [16*bitsize-1:0] r_pix;
  pix_t                  w_pix   [16];
  rnd_t                  w_v;

  // Coefficient store; a write is seen by windows from the next cycle on
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 16; c++) r_coef[c] <= '0;
    end else if (wt_wr_en) begin
      r_coef[wt_ch] <= wt_data;
    end
  end

  // S1: tap products; bias snapshot travels with the window
  always_ff @(posedge clk) begin
    for (int c = 0; c < 16; c++) begin
      for (int t = 0; t < 25; t++) begin
        r_prod[c][t] <=
          prod_t'(pix_t'(window_in[(c*25+t)*bitsize +: bitsize])) *
          prod_t'(pix_t'(r_coef[c][t*bitsize +: bitsize]));
      end
      r_bias1[c] <= pix_t'(r_coef[c][25*bitsize +: bitsize]);
    end
  end

  // S2: five partial sums of five products each
  always_ff @(posedge clk) begin
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 5; k++) begin
        r_part[c][k] <= part_t'(r_prod[c][5*k])
                      + part_t'(r_prod[c][5*k+1])
                      + part_t'(r_prod[c][5*k+2])
                      + part_t'(r_prod[c][5*k+3])
                      + part_t'(r_prod[c][5*k+4]);
      end
      r_bias2[c] <= r_bias1[c];
    end
  end

  // S3: full sum plus bias aligned to the product scale
  always_ff @(posedge clk) begin
    for (int c = 0; c < 16; c++) begin
      r_sum[c] <= sum_t'(r_part[c][0]) + sum_t'(r_part[c][1])
                + sum_t'(r_part[c][2]) + sum_t'(r_part[c][3])
                + sum_t'(r_part[c][4])
                + (sum_t'(r_bias2[c]) <<< FRAC_BITS);
    end
  end

  // S4 comb: round half up, rescale, saturate (and optional ReLU6)
  always_comb begin
    w_v = '0;
    for (int c = 0; c < 16; c++) begin
      w_v = (rnd_t'(r_sum[c]) + HALF) >>> FRAC_BITS;
      if (w_v > MAXV) w_v = MAXV;
      else if (w_v < MINV) w_v = MINV;
`ifdef DW5_RELU6_EN
      if (w_v < 0) w_v = '0;
      else if (w_v > R6) w_v = R6;
`endif
      w_pix[c] = pix_t'(w_v);
    end
  end

  // Valid/last shift register aligned with the data stages
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[2:0], window_valid};
      r_lst <= {r_lst[2:0], window_valid & window_last};
    end
  end

  // Output register; holds between results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix <= '0;
    end else if (r_vld[2]) begin
      for (int c = 0; c < 16; c++) r_pix[c*bitsize +: bitsize] <= w_pix[c];
    end
  end

  // Results since the last slice end, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_vld[3] && r_lst[3]) begin
      r_cnt <= '0;
    end else if (r_vld[3] && r_cnt != 12'hFFF) begin
      r_cnt <= r_cnt + 12'd1;
    end
  end

  assign out_pixels = r_pix;
  assign out_valid  = r_vld[3];
  assign out_last   = r_lst[3];
  assign window_cnt = r_cnt;

endmodule

// File: doc/dw_conv5x5x16.md
# dw_conv5x5x16

Depthwise 5x5 convolution engine. It sits directly downstream of the 16-channel 5x5 window FIFO and consumes one 16-channel window per valid cycle. For each channel it computes the 25-tap dot product against per-channel weights, adds a per-channel bias, and rounds and saturates the result back to the pixel format. It emits 16 output pixels on a fixed 4-cycle pipeline with no backpressure.

## Interface
- bitsize, 14, pixel/weight/bias width (signed fixed point)
- FRAC_BITS, 7, fractional bits of pixels, weights, bias and output
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- window_in  in  25*16*bitsize  channel c occupies bits [c*25*bitsize +: 25*bitsize]; tap t (row-major, 0..24) at [t*bitsize +: bitsize] within the channel
- window_valid  in  1  window_in is valid this cycle
- window_last  in  1  last window of the current depth slice; qualified by window_valid
- wt_wr_en  in  1  write one channel's weights and bias
- wt_ch  in  4  channel index for the write
- wt_data  in  26*bitsize  taps 0..24 at [t*bitsize +: bitsize]; bias at [25*bitsize +: bitsize]
- out_pixels  out  16*bitsize  channel c result at [c*bitsize +: bitsize]
- out_valid  out  1  out_pixels valid
- out_last  out  1  out_valid result belongs to a window_last window
- window_cnt  out  12  number of out_valid results since the last out_last

## Operation
- Weight/bias storage: 16 channels x (25 taps + 1 bias) registers, reset to 0.
  - On wt_wr_en, wt_data is stored to channel wt_ch.
  - A write at cycle T affects windows accepted from T+1 onward.
  - A window accepted at cycle T uses the coefficients held at T.
- Pipeline (per channel, all 16 channels in parallel):
  - S1: 25 signed products, each 2*bitsize wide, registered.
  - S2: five partial sums of 5 products each, 2*bitsize+3 wide.
  - S3: sum of the 5 partials plus (bias <<< FRAC_BITS), 2*bitsize+6 wide.
  - S4: add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, saturate to [-2^(bitsize-1), 2^(bitsize-1)-1], then register to out_pixels.
- All intermediate arithmetic is signed and sign-extended; no wrap at any stage.
- window_valid and window_last travel through a 4-deep shift register alongside the data, becoming out_valid and out_last.
- out_pixels holds its last value when out_valid=0.
- window_cnt counter:
  - Increments on each out_valid.
  - When out_valid & out_last, it loads 0, so it reads 0 on the cycle after the last result.
  - Saturates at 4095.
- There is no stall path: every accepted window produces exactly one result.

## Timing
- Latency: window_valid at T gives out_valid at T+4.
- Throughput: 1 window per cycle; back-to-back windows give back-to-back outputs.
- Reset values: out_pixels=0, out_valid=0, out_last=0, window_cnt=0, all pipeline valids=0, all weights and biases=0.
- Reset mid-operation:
  - Every window in flight is discarded, so no out_valid follows.
  - Windows presented in the cycle rst is high are ignored.
- window_last without window_valid is ignored.
- wt_wr_en during rst is ignored.
- When a weight write and window_valid occur in the same cycle, the window uses the old coefficients.

## Configuration
- DW5_RELU6_EN defined:
  - S4 additionally clamps each saturated result to [0, 6<<FRAC_BITS] (768 at defaults).
  - Latency is unchanged.
- DW5_RELU6_EN undefined: the output is the signed saturated result only, with no activation.

## Test plan
(defaults bitsize=14, FRAC_BITS=7; 1.0=128)
- Unity conv:
  - Stimulus: channel 0 all taps 128, bias 0; window all 128, valid at T.
  - Required response: out_valid at T+4, channel 0 = 3200, other channels 0 (or 3200 clamped to 768 with DW5_RELU6_EN).
- Saturation:
  - Stimulus: all taps 8191 with pixels 8191; then pixels -8192.
  - Required response: 8191 and -8192 (0 with DW5_RELU6_EN).
- Rounding:
  - Stimulus: tap0=1, other taps 0, bias 0; pixel0 = 64, 63, -64, -65.
  - Required response: outputs 1, 0, 0, -1.
- Bias: taps 0, bias -5 -> output -5 (0 with DW5_RELU6_EN).
- Stream:
  - Stimulus: 3 back-to-back windows, window_last on the third.
  - Required response: out_valid high 3 consecutive cycles, out_last only on the third; window_cnt goes 1, 2, then 0.
- Coefficient timing and reset:
  - Stimulus: wt_wr_en (channel 0 taps 0→128) in the same cycle as window A, with window B the next cycle.
  - Required response: A uses the old weights, B uses the new ones.
  - Stimulus: rst pulsed at T+2 after a window at T.
  - Required response: no out_valid at T+4; all outputs read 0.
